interp_sequencer: RTL

Reader side of the interpolation step-register bank. On a start pulse it snapshots one pilot estimate (base) and the precomputed step multiples E, 2E and 5E, then emits the six sequential channel-estimate samples H0 … H0+5E over a valid/ready stream. It sits between the interpolation step registers and the downstream estimate buffer, and processes one real lane; I and Q each use one instance.

---
 rtl/interp_pkg.sv | 20 ++
 rtl/interp_sat.sv | 40 ++++
 rtl/interp_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation reader: default lane widths,
// sequencer state encoding and the index of the final sample in a run.
package interp_pkg;

  // Default widths for one real lane
  localparam int BASE_W = 16;  // pilot estimate H0
  localparam int REG1   = 17;  // step E
  localparam int REG2   = 18;  // step 2E
  localparam int REG3   = 20;  // step 5E
  localparam int OUT_W  = 16;  // emitted sample

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  // Six samples per run, indexed 0..5
  localparam logic [2:0] LAST_IDX = 3'd5;

endpackage

// File: rtl/interp_sat.sv
// Reduces the full-precision interpolation sum to the output sample width.
// Build option: INTERP_SAT_EN defined -> clamp to the signed OUT_W range;
// undefined -> keep the low OUT_W bits (two's-complement wrap).
module interp_sat #(
  parameter int IN_W  = 21,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  sum_i,
  output logic signed [OUT_W-1:0] sat_o
);

`ifdef INTERP_SAT_EN
  localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

  logic fits;

  // The sum fits when every bit above the output sign bit copies the sign
  always_comb begin
    // NOTE: every output of a combinational block gets a value on every
    // path; a missing assignment would infer a latch.
    fits = (sum_i[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){sum_i[IN_W-1]}});
    if (fits) begin
      sat_o = sum_i[OUT_W-1:0];
    end else if (sum_i[IN_W-1]) begin
      sat_o = MIN_V;
    end else begin
      sat_o = MAX_V;
    end
  end
`else
  // High bits are intentionally discarded in the wrapping build
  logic unused_hi;
  assign unused_hi = ^sum_i[IN_W-1:OUT_W];

  // Keep the low bits: two's-complement wrap
  assign sat_o = sum_i[OUT_W-1:0];
`endif

endmodule

// File: rtl/interp_sequencer.sv
// Interpolation step-register reader for one real lane. A start pulse
// snapshots H0, E, 2E and 5E; the block then streams the six samples
// H0 .. H0+5E over a valid/ready handshake with registered outputs.
// Build option: INTERP_SAT_EN selects saturation instead of wrap in the
// output reducer (see interp_sat).
module interp_sequencer
  import interp_pkg::*;
#(
  parameter int BASE_W = interp_pkg::BASE_W,
  parameter int REG1   = interp_pkg::REG1,
  parameter int REG2   = interp_pkg::REG2,
  parameter int REG3   = interp_pkg::REG3,
  parameter int OUT_W  = interp_pkg::OUT_W
) (
  input  logic                     clk,
  input  logic                     rst,        // asynchronous, active low
  input  logic                     start,
  input  logic signed [BASE_W-1:0] base,
  input  logic signed [REG1-1:0]   reg_E,
  input  logic signed [REG2-1:0]   reg_2E,
  input  logic signed [REG3-1:0]   reg_5E,
  input  logic                     est_ready,
  output logic                     est_valid,
  output logic signed [OUT_W-1:0]  est_data,
  output logic [2:0]               est_idx,
  output logic                     est_last,
  output logic                     busy
);

  localparam int SUM_W = REG3 + 1;

  state_e                    state_q;
  logic signed [BASE_W-1:0]  base_q;
  logic signed [REG1-1:0]    e_q;
  logic signed [REG2-1:0]    e2_q;
  logic signed [REG3-1:0]    e5_q;
  logic [2:0]                idx_q;
  logic                      valid_q;
  logic signed [OUT_W-1:0]   data_q;
  logic                      last_q;
  logic                      busy_q;

  logic [2:0]                idx_nxt;
  logic signed [SUM_W-1:0]   b_x, e_x, e2_x, e5_x;
  logic signed [SUM_W-1:0]   sum_d;
  logic signed [OUT_W-1:0]   sat_d;

  // Full-precision value of the sample that will be registered next: H0
  // straight from the input when a run starts, otherwise the snapshot sum
  // for the following index.
  always_comb begin
    idx_nxt = idx_q + 3'd1;
    b_x     = SUM_W'(base_q);
    e_x     = SUM_W'(e_q);
    e2_x    = SUM_W'(e2_q);
    e5_x    = SUM_W'(e5_q);
    sum_d   = b_x;
    if (state_q == IDLE) begin
      sum_d = SUM_W'(base);
    end else begin
      case (idx_nxt)
        3'd1:    sum_d = b_x + e_x;
        3'd2:    sum_d = b_x + e2_x;
        3'd3:    sum_d = (b_x + e2_x) + e_x;
        3'd4:    sum_d = (b_x + e5_x) - e_x;
        3'd5:    sum_d = b_x + e5_x;
        default: sum_d = b_x;
      endcase
    end
  end

  interp_sat #(
    .IN_W  (SUM_W),
    .OUT_W (OUT_W)
  ) u_sat (
    .sum_i (sum_d),
    .sat_o (sat_d)
  );

  // Run sequencing, snapshot capture and registered stream outputs
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      e_q     <= '0;
      e2_q    <= '0;
      e5_q    <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            base_q  <= base;
            e_q     <= reg_E;
            e2_q    <= reg_2E;
            e5_q    <= reg_5E;
            idx_q   <= '0;
            data_q  <= sat_d;
            last_q  <= 1'b0;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          // start is ignored for the whole run, including the final transfer
          if (est_ready) begin
            if (idx_q == LAST_IDX) begin
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              last_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              idx_q  <= idx_nxt;
              data_q <= sat_d;
              last_q <= (idx_nxt == LAST_IDX);
            end
          end
        end
      endcase
    end
  end

  assign est_valid = valid_q;
  assign est_data  = data_q;
  assign est_idx   = idx_q;
  assign est_last  = last_q;
  assign busy      = busy_q;

endmodule
